syncgen_multi: RTL and testbench



---
 rtl/syncgen_pkg.sv | 41 ++++
 rtl/syncgen_axis.sv | 62 ++++++
 rtl/syncgen_multi.sv | 137 +++++++++++++
 tb/tb_syncgen_multi.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/syncgen_pkg.sv
// syncgen_pkg: timing types and preset timing sets for syncgen_multi.
// Contents: timing_t (one axis), mode_timing_t (h + v), 720p/1080p presets.
package syncgen_pkg;

    localparam int TIMING_W = 16;

    typedef struct packed {
        logic [TIMING_W-1:0] total;
        logic [TIMING_W-1:0] sync;
        logic [TIMING_W-1:0] backp;
        logic [TIMING_W-1:0] active;
    } timing_t;

    typedef struct packed {
        timing_t h;
        timing_t v;
    } mode_timing_t;

    localparam mode_timing_t TIMING_720P = '{
        h: '{total: 16'd1650, sync: 16'd40,
             backp: 16'd220, active: 16'd1280},
        v: '{total: 16'd750, sync: 16'd5,
             backp: 16'd20, active: 16'd720}
    };

    localparam mode_timing_t TIMING_1080P = '{
        h: '{total: 16'd2200, sync: 16'd44,
             backp: 16'd148, active: 16'd1920},
        v: '{total: 16'd1125, sync: 16'd5,
             backp: 16'd36, active: 16'd1080}
    };

    function automatic mode_timing_t pick_mode(
        input logic         sel,
        input mode_timing_t m0,
        input mode_timing_t m1
    );
        return sel ? m1 : m0;
    endfunction

endpackage

// File: rtl/syncgen_axis.sv
// syncgen_axis: one position counter axis with wrap, sync and blank flags.
// Ports: video_clk, reset, en (advance), cur_total (wrap point of the
// timing in effect), nxt_t (timing for the next position), nxt_pos,
// wrap, nxt_act (next position active), sync, blank (registered).
module syncgen_axis
    import syncgen_pkg::*;
#(
    parameter int   CNT_W    = 12,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic                video_clk,
    input  logic                reset,
    input  logic                en,
    input  logic [TIMING_W-1:0] cur_total,
    input  timing_t             nxt_t,
    output logic [CNT_W-1:0]    nxt_pos,
    output logic                wrap,
    output logic                nxt_act,
    output logic                sync,
    output logic                blank
);

    localparam int W = CNT_W + 1;

    logic [CNT_W-1:0] pos;
    logic [W-1:0]     pos_w;
    logic [W-1:0]     last;
    logic [W-1:0]     np_w;
    logic [W-1:0]     n_sync;
    logic [W-1:0]     n_start;
    logic [W-1:0]     n_end;
    logic             unused_bits;

    assign pos_w   = {1'b0, pos};
    assign last    = W'(cur_total) - W'(1);
    assign wrap    = (pos_w == last);
    assign nxt_pos = !en  ? pos :
                     wrap ? '0  : pos + CNT_W'(1);

    // Flags for the next position use the timing that will be in
    // effect there, so a mode change lands cleanly on (0,0).
    assign np_w    = {1'b0, nxt_pos};
    assign n_sync  = W'(nxt_t.sync);
    assign n_start = W'(nxt_t.sync) + W'(nxt_t.backp);
    assign n_end   = n_start + W'(nxt_t.active);
    assign nxt_act = (np_w >= n_start) && (np_w < n_end);

    assign unused_bits = ^{cur_total, nxt_t};

    always_ff @(posedge video_clk) begin
        if (reset) begin
            pos   <= CNT_W'(nxt_t.total - TIMING_W'(1));
            sync  <= ~SYNC_POL;
            blank <= 1'b1;
        end else begin
            pos   <= nxt_pos;
            sync  <= (np_w < n_sync) ? SYNC_POL : ~SYNC_POL;
            blank <= ~nxt_act;
        end
    end

endmodule

// File: rtl/syncgen_multi.sv
// syncgen_multi: two-mode video timing generator with line prefetch pulse.
// Ports: video_clk, reset, mode_sel in; mode_active, framestart, linestart,
// prefetch_line, prefetch_y, pixelena, hsync, vsync, hblank, vblank,
// pixel_x, pixel_y out. Coordinates only when SYNCGEN_COORD_EN is defined.
module syncgen_multi
    import syncgen_pkg::*;
#(
    parameter int           CNT_W          = 12,
    parameter mode_timing_t MODE0          = TIMING_720P,
    parameter mode_timing_t MODE1          = TIMING_1080P,
    parameter logic         HSYNC_POL      = 1'b1,
    parameter logic         VSYNC_POL      = 1'b1,
    parameter int           PREFETCH_LINES = 2
) (
    input  logic             video_clk,
    input  logic             reset,
    input  logic             mode_sel,
    output logic             mode_active,
    output logic             framestart,
    output logic             linestart,
    output logic             prefetch_line,
    output logic [CNT_W-1:0] prefetch_y,
    output logic             pixelena,
    output logic             hsync,
    output logic             vsync,
    output logic             hblank,
    output logic             vblank,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y
);

    localparam int W = CNT_W + 1;

    logic                h_wrap;
    logic                v_wrap;
    logic                h_act;
    logic                v_act;
    logic [CNT_W-1:0]    h_nxt;
    logic [CNT_W-1:0]    v_nxt;
    logic                frame_end;
    logic                mode_nxt;
    mode_timing_t        nxt_m;
    logic [TIMING_W-1:0] h_cur_tot;
    logic [TIMING_W-1:0] v_cur_tot;
    logic [W-1:0]        v_start;
    logic [W-1:0]        v_end;
    logic [W-1:0]        v_ahead;
    logic                line0;
    logic                pf_d;

    // mode_sel is only honoured at the last pixel of a frame (or in
    // reset), so the new timing starts exactly at the next (0,0).
    assign frame_end = h_wrap & v_wrap;
    assign mode_nxt  = (reset | frame_end) ? mode_sel : mode_active;
    assign nxt_m     = pick_mode(mode_nxt, MODE0, MODE1);
    assign h_cur_tot = mode_active ? MODE1.h.total : MODE0.h.total;
    assign v_cur_tot = mode_active ? MODE1.v.total : MODE0.v.total;

    syncgen_axis #(
        .CNT_W    (CNT_W),
        .SYNC_POL (HSYNC_POL)
    ) u_h (
        .video_clk (video_clk),
        .reset     (reset),
        .en        (1'b1),
        .cur_total (h_cur_tot),
        .nxt_t     (nxt_m.h),
        .nxt_pos   (h_nxt),
        .wrap      (h_wrap),
        .nxt_act   (h_act),
        .sync      (hsync),
        .blank     (hblank)
    );

    syncgen_axis #(
        .CNT_W    (CNT_W),
        .SYNC_POL (VSYNC_POL)
    ) u_v (
        .video_clk (video_clk),
        .reset     (reset),
        .en        (h_wrap),
        .cur_total (v_cur_tot),
        .nxt_t     (nxt_m.v),
        .nxt_pos   (v_nxt),
        .wrap      (v_wrap),
        .nxt_act   (v_act),
        .sync      (vsync),
        .blank     (vblank)
    );

    assign line0   = (h_nxt == '0);
    assign v_start = W'(nxt_m.v.sync) + W'(nxt_m.v.backp);
    assign v_end   = v_start + W'(nxt_m.v.active);
    assign v_ahead = {1'b0, v_nxt} + W'(PREFETCH_LINES);
    assign pf_d    = line0 && (v_ahead >= v_start) && (v_ahead < v_end);

    always_ff @(posedge video_clk) begin
        if (reset) begin
            mode_active   <= mode_sel;
            framestart    <= 1'b0;
            linestart     <= 1'b0;
            prefetch_line <= 1'b0;
            prefetch_y    <= '0;
            pixelena      <= 1'b0;
        end else begin
            mode_active   <= mode_nxt;
            framestart    <= line0 && (v_nxt == '0);
            linestart     <= line0 && v_act;
            prefetch_line <= pf_d;
            prefetch_y    <= pf_d ? CNT_W'(v_ahead - v_start) : '0;
            pixelena      <= h_act && v_act;
        end
    end

`ifdef SYNCGEN_COORD_EN
    logic [W-1:0] h_start;

    assign h_start = W'(nxt_m.h.sync) + W'(nxt_m.h.backp);

    always_ff @(posedge video_clk) begin
        if (reset) begin
            pixel_x <= '0;
            pixel_y <= '0;
        end else if (h_act && v_act) begin
            pixel_x <= CNT_W'({1'b0, h_nxt} - h_start);
            pixel_y <= CNT_W'({1'b0, v_nxt} - v_start);
        end else begin
            pixel_x <= '0;
            pixel_y <= '0;
        end
    end
`else
    assign pixel_x = '0;
    assign pixel_y = '0;
`endif

endmodule

// File: tb/tb_syncgen_multi.sv
// tb_syncgen_multi: scoreboard bench for syncgen_multi with small
// custom timings; reference model is a plain position/formula model.
module tb_syncgen_multi;
    import syncgen_pkg::*;

    localparam int   CW   = 12;
    localparam int   PF   = 2;
    localparam logic HPOL = 1'b0;
    localparam logic VPOL = 1'b1;

    localparam int HT[2] = '{20, 24};
    localparam int HS[2] = '{2, 3};
    localparam int HB[2] = '{3, 4};
    localparam int HA[2] = '{10, 14};
    localparam int VT[2] = '{12, 11};
    localparam int VS[2] = '{2, 1};
    localparam int VB[2] = '{2, 3};
    localparam int VA[2] = '{6, 5};

    localparam mode_timing_t T0 = '{
        h: '{total: 16'd20, sync: 16'd2, backp: 16'd3, active: 16'd10},
        v: '{total: 16'd12, sync: 16'd2, backp: 16'd2, active: 16'd6}
    };
    localparam mode_timing_t T1 = '{
        h: '{total: 16'd24, sync: 16'd3, backp: 16'd4, active: 16'd14},
        v: '{total: 16'd11, sync: 16'd1, backp: 16'd3, active: 16'd5}
    };

    typedef struct packed {
        logic          ma;
        logic          fs;
        logic          ls;
        logic          pf;
        logic [CW-1:0] pfy;
        logic          pe;
        logic          hs;
        logic          vs;
        logic          hb;
        logic          vb;
        logic [CW-1:0] px;
        logic [CW-1:0] py;
    } obs_t;

    logic          video_clk = 1'b0;
    logic          reset;
    logic          mode_sel;
    logic          mode_active;
    logic          framestart;
    logic          linestart;
    logic          prefetch_line;
    logic [CW-1:0] prefetch_y;
    logic          pixelena;
    logic          hsync;
    logic          vsync;
    logic          hblank;
    logic          vblank;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int mx = 0;
    int my = 0;
    int mm = 0;
    obs_t exp_q[$];
    obs_t act;

    syncgen_multi #(
        .CNT_W          (CW),
        .MODE0          (T0),
        .MODE1          (T1),
        .HSYNC_POL      (HPOL),
        .VSYNC_POL      (VPOL),
        .PREFETCH_LINES (PF)
    ) dut (
        .video_clk     (video_clk),
        .reset         (reset),
        .mode_sel      (mode_sel),
        .mode_active   (mode_active),
        .framestart    (framestart),
        .linestart     (linestart),
        .prefetch_line (prefetch_line),
        .prefetch_y    (prefetch_y),
        .pixelena      (pixelena),
        .hsync         (hsync),
        .vsync         (vsync),
        .hblank        (hblank),
        .vblank        (vblank),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y)
    );

    always #5 video_clk = ~video_clk;

    assign act = {mode_active, framestart, linestart, prefetch_line,
                  prefetch_y, pixelena, hsync, vsync, hblank, vblank,
                  pixel_x, pixel_y};

    function automatic obs_t reset_vals(input logic sel);
        obs_t o;
        o    = '0;
        o.ma = sel;
        o.hs = ~HPOL;
        o.vs = ~VPOL;
        o.hb = 1'b1;
        o.vb = 1'b1;
        return o;
    endfunction

    function automatic obs_t expect_at(input int x, input int y,
                                       input int m);
        obs_t o;
        int   hst;
        int   vst;
        bit   ha;
        bit   va;
        bit   in_pf;
        hst   = HS[m] + HB[m];
        vst   = VS[m] + VB[m];
        ha    = (x >= hst) && (x < hst + HA[m]);
        va    = (y >= vst) && (y < vst + VA[m]);
        in_pf = (x == 0) && (y + PF >= vst) && (y + PF < vst + VA[m]);
        o     = '0;
        o.ma  = (m == 1);
        o.fs  = (x == 0) && (y == 0);
        o.ls  = (x == 0) && va;
        o.pf  = in_pf;
        o.pfy = in_pf ? CW'(y + PF - vst) : '0;
        o.pe  = ha && va;
        o.hs  = (x < HS[m]) ? HPOL : ~HPOL;
        o.vs  = (y < VS[m]) ? VPOL : ~VPOL;
        o.hb  = !ha;
        o.vb  = !va;
`ifdef SYNCGEN_COORD_EN
        if (o.pe) begin
            o.px = CW'(x - hst);
            o.py = CW'(y - vst);
        end
`endif
        return o;
    endfunction

    // Reference model: advance the position one pixel per clock and
    // push the outputs that position should show.
    always @(posedge video_clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            mm = mode_sel ? 1 : 0;
            mx = HT[mm] - 1;
            my = VT[mm] - 1;
            exp_q.push_back(reset_vals(mode_sel));
        end else begin
            if (mx == HT[mm] - 1 && my == VT[mm] - 1) begin
                mm = mode_sel ? 1 : 0;
                mx = 0;
                my = 0;
            end else if (mx == HT[mm] - 1) begin
                mx = 0;
                my = my + 1;
            end else begin
                mx = mx + 1;
            end
            exp_q.push_back(expect_at(mx, my, mm));
        end
    end

    always @(negedge video_clk) begin
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d pos=(%0d,%0d) mode=%0d got=%h expected=%h",
                         cyc, mx, my, mm, act, e);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge video_clk);
    endtask

    task automatic toggle_at_frame_end();
        int k;
        k = 0;
        while (!(mx == HT[mm] - 1 && my == VT[mm] - 1) && k < 1000) begin
            step(1);
            k++;
        end
        if (k >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_end_wait got=timeout expected=frame end within 1000 cycles");
        end else begin
            mode_sel = ~mode_sel;
            step(1);
        end
    endtask

    initial begin
        reset    = 1'b1;
        mode_sel = 1'b0;
        step(3);
        reset = 1'b0;
        step(310);
        mode_sel = 1'b1;
        step(600);
        toggle_at_frame_end();
        step(300);
        toggle_at_frame_end();
        step(150);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(300);
        mode_sel = 1'b0;
        step(100);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(300);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) mode_sel = ~mode_sel;
            reset = ($urandom_range(0, 699) == 0);
            step(1);
        end
        reset = 1'b0;
        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
